mem: RTL and testbench
======================

MEM -- requirements
Module: mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, word-address width; depth = 2**ADDR_WIDTH words (256 by default).
REQ-002 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 clk  input  1  single clock, rising-edge active; the only clock in the block.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 w_en  input  1  write enable, sampled on rising clk edge.
REQ-006 addr  input  ADDR_WIDTH  word address, shared by read and write.
REQ-007 data_in  input  DATA_WIDTH  write data.
REQ-008 data_out  output  DATA_WIDTH  read data for the word at addr.

Function
REQ-009 The block SHALL hold 2**ADDR_WIDTH words of DATA_WIDTH bits each, implemented as flip-flops so that all words are resettable.
REQ-010 Write: on a rising clk edge with rst=0 and w_en=1, the word at addr SHALL be replaced by data_in.
REQ-011 Writes SHALL take effect at that edge, with a latency of one edge.
REQ-012 With w_en=0, a clock edge SHALL leave every word unchanged.
REQ-013 Writes SHALL modify only the addressed word; all other words are unchanged.
REQ-014 Read: data_out SHALL be the combinational value of the word at the current addr.
REQ-015 Read latency SHALL be zero cycles: a change on addr is reflected on data_out in the same cycle.
REQ-016 Read during write to the same address: before the edge, data_out shows the old word; after the edge, it shows data_in.
REQ-017 No read-enable SHALL exist; data_out is always driven.
REQ-018 Every addr value 0 .. 2**ADDR_WIDTH-1 SHALL be valid; there is no wrap or out-of-range case.
REQ-019 Back-to-back writes on consecutive cycles, to the same or different addresses, SHALL each complete; the last write to an address wins.
REQ-020 w_en, addr and data_in SHALL be treated as synchronous inputs, stable around the rising edge.

Reset
REQ-021 While rst=1, every word SHALL be cleared to 0 immediately, independent of clk.
REQ-022 While rst=1, data_out SHALL read 0 for any addr.
REQ-023 While rst=1, writes SHALL be ignored, including when w_en=1.
REQ-024 If rst asserts in the same cycle as a write, reset SHALL win and the word ends at 0.
REQ-025 After rst deasserts, the first rising edge with w_en=1 SHALL perform a normal write.
REQ-026 No cycle penalty SHALL follow reset deassertion.

Verification
REQ-027 Reset check: pulse rst, then read addr 0, 1, 2 and 255 -> data_out=32'h0 for each.
REQ-028 Basic write/read: w_en=1, addr=1, data_in=32'h12345678, one edge; then w_en=0, addr=1 -> data_out=32'h12345678.
REQ-029 Second address: w_en=1, addr=2, data_in=32'h87654321, one edge; then w_en=0, addr=2 -> data_out=32'h87654321.
REQ-029a Isolation, continuing REQ-029: addr=1 -> data_out still 32'h12345678.
REQ-030 Write-disabled: w_en=0, addr=1, data_in=32'hDEADBEEF, several edges -> addr 1 still reads 32'h12345678.
REQ-031 Boundary and overwrite: write 32'hFFFFFFFF to addr 255, then write 32'hA5A5A5A5 to addr 255 -> data_out=32'hA5A5A5A5.
REQ-031a Boundary isolation, continuing REQ-031: addr 0 still reads 0.
REQ-032 Asynchronous reset mid-operation: after the writes above, raise rst between clock edges -> data_out goes to 0 at once, with no clock edge needed.
REQ-032a Post-reset check: after rst deasserts, addr 1, 2 and 255 each read 0.

Source files
------------

// File: rtl/mem_if.sv
// Bus bundle for the mem word store.
//   w_en     : write enable, sampled on the rising clock edge
//   addr     : word address, shared by read and write
//   data_in  : write data
//   data_out : combinational read data for the word at addr
// master drives the request side; slave is the storage array.
interface mem_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  w_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;

   modport master (
      output w_en,
      output addr,
      output data_in,
      input  data_out
   );

   modport slave (
      input  w_en,
      input  addr,
      input  data_in,
      output data_out
   );
endinterface

// File: rtl/mem.sv
// Flip-flop based word store with zero-latency read and one-edge write.
// Every word is a register, so the whole array clears on reset.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset; clears every word
//   bus : mem_if.slave -- w_en/addr/data_in in, data_out out
// A read during a write to the same address returns the old word until the
// edge, then the new one, because data_out is taken straight from the array.
module mem #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   mem_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (bus.w_en) begin
         mem_d[bus.addr] = bus.data_in;
      end
   end

   // Reset wins over any write in the same cycle, and holds the array at
   // zero for as long as rst stays high, clock edges included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign bus.data_out = mem_q[bus.addr];
endmodule

// File: tb/tb_mem.sv
module tb_mem;
   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   mem_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

   mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
      bus.addr = a;
      #1;
      check(tag, bus.data_out, exp);
   endtask

   task automatic write_word(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.addr    = a;
      bus.data_in = d;
      bus.w_en    = 1'b1;
      @(posedge clk);
      #1;
      bus.w_en = 1'b0;
   endtask

   initial begin
      rst          = 1'b0;
      bus.w_en     = 1'b0;
      bus.addr     = '0;
      bus.data_in  = '0;
      #1 rst = 1'b1;

      // reset clears before any clock edge has occurred
      read_chk("rst_async_a0", 8'd0, 32'h0);
      @(negedge clk);
      read_chk("rst_a0",   8'd0,   32'h0);
      read_chk("rst_a1",   8'd1,   32'h0);
      read_chk("rst_a2",   8'd2,   32'h0);
      read_chk("rst_a255", 8'd255, 32'h0);

      // write attempted while reset is held is ignored
      @(negedge clk);
      bus.addr = 8'd7; bus.data_in = 32'hCAFEF00D; bus.w_en = 1'b1;
      @(posedge clk); #1;
      bus.w_en = 1'b0;
      read_chk("wr_in_rst", 8'd7, 32'h0);

      @(negedge clk);
      rst = 1'b0;

      // first edge after reset performs a normal write
      write_word(8'd1, 32'h12345678);
      read_chk("basic_a1", 8'd1, 32'h12345678);

      write_word(8'd2, 32'h87654321);
      read_chk("second_a2", 8'd2, 32'h87654321);
      read_chk("iso_a1",    8'd1, 32'h12345678);

      // write disabled across several edges
      @(negedge clk);
      bus.addr = 8'd1; bus.data_in = 32'hDEADBEEF; bus.w_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("wdis_a1", bus.data_out, 32'h12345678);

      // read during write: old value before the edge, new after
      @(negedge clk);
      bus.addr = 8'd2; bus.data_in = 32'h0BADC0DE; bus.w_en = 1'b1;
      #1;
      check("rdw_before", bus.data_out, 32'h87654321);
      @(posedge clk); #1;
      bus.w_en = 1'b0;
      check("rdw_after", bus.data_out, 32'h0BADC0DE);

      // back-to-back writes, last write wins
      write_word(8'd3, 32'h11111111);
      write_word(8'd3, 32'h22222222);
      write_word(8'd4, 32'h33333333);
      read_chk("b2b_a3", 8'd3, 32'h22222222);
      read_chk("b2b_a4", 8'd4, 32'h33333333);

      // boundary address and overwrite
      write_word(8'd255, 32'hFFFFFFFF);
      read_chk("bnd_first", 8'd255, 32'hFFFFFFFF);
      write_word(8'd255, 32'hA5A5A5A5);
      read_chk("bnd_over", 8'd255, 32'hA5A5A5A5);
      read_chk("bnd_a0",   8'd0,   32'h0);
      read_chk("bnd_a254", 8'd254, 32'h0);

      // asynchronous reset between edges
      @(negedge clk);
      bus.addr = 8'd255;
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_a255", bus.data_out, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      read_chk("post_a1",   8'd1,   32'h0);
      read_chk("post_a2",   8'd2,   32'h0);
      read_chk("post_a255", 8'd255, 32'h0);

      // no penalty after reset release
      write_word(8'd9, 32'h5A5AA5A5);
      read_chk("post_wr_a9", 8'd9, 32'h5A5AA5A5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
